// File: rtl/mobius_loader.sv
// mobius_loader: gathers W-bit truth-table words into one N-bit vector and
// hands the full vector to the transform stage.
//
// Both ports use the same valid/ready rule: a transfer happens on a rising
// edge where valid and ready are both 1. A producer holds its payload until
// that edge. The loader raises in_ready only in FILL and out_valid only in
// HOLD, so it never accepts a word and hands off a vector in the same cycle.
module mobius_loader #(
  parameter int N      = 128,
  parameter int log2_N = 7,
  parameter int W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:W-1]      in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_data,
  output logic              err,
  output logic [7:0]        frames,
  output logic              dbg_state,
  output logic [log2_N-1:0] dbg_cnt
);

  localparam int BEATS = N / W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] cnt;
  logic [0:N-1]  tt_q;
  logic          live;
  logic          accept;
  logic          handoff;
  logic          at_last;
  logic          err_d;

  assign at_last   = (cnt == LAST_CNT);
  assign out_data  = tt_q;
  assign dbg_state = state;
  assign dbg_cnt   = log2_N'(cnt);

  // State register; any reset drops the current frame without side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_d;
    end
  end

  // Next state and handshake outputs.
  // A mismatch between in_last and the final beat position is a framing
  // error: an early last aborts the frame, a missing last still completes it.
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    handoff   = 1'b0;
    err_d     = 1'b0;
    case (state)
      FILL: begin
        in_ready = live;
        accept   = in_valid && live;
        if (accept) begin
          err_d = (in_last != at_last);
          if (at_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          handoff = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Datapath: word buffer, beat counter, error pulse, handoff counter.
  // live holds in_ready low until the first edge after reset is released.
  // The buffer is not cleared on an early last; the next frame overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tt_q   <= '0;
      err    <= 1'b0;
      frames <= 8'd0;
      live   <= 1'b0;
    end else begin
      live <= 1'b1;
      err  <= err_d;
      if (accept) begin
        tt_q[int'(cnt) * W +: W] <= in_data;
        if (at_last || in_last) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (handoff) begin
        frames <= frames + 8'd1;
      end
    end
  end

endmodule

// File: doc/mobius_loader.md
MOBIUS_LOADER -- requirements
Module: mobius_loader

Interface
REQ-001 Parameter N, default 128, meaning: truth-table length in bits (power of two, must be at least W).
REQ-002 Parameter log2_N, default 7, meaning: log2 of N.
REQ-003 Parameter W, default 8, meaning: input word width in bits (power of two, divides N).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port: clk, input, 1, rising-edge clock.
REQ-006 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port: in_valid, input, 1, upstream word valid.
REQ-008 Port: in_ready, output, 1, loader accepts a word this cycle.
REQ-009 Port: in_data, input, [0:W-1], truth-table word, bit 0 = lowest table index.
REQ-010 Port: in_last, input, 1, upstream marks final word of a frame.
REQ-011 Port: out_valid, output, 1, full N-bit vector available to the transform stage.
REQ-012 Port: out_ready, input, 1, transform stage takes the vector this cycle.
REQ-013 Port: out_data, output, [0:N-1], assembled truth table, index 0 leftmost.
REQ-014 Port: err, output, 1, one-cycle framing-error pulse.
REQ-015 Port: frames, output, 8, count of vectors handed off.

Function
REQ-016 The block SHALL implement two states, FILL and HOLD, with a beat counter cnt of width log2(N/W).
REQ-017 In FILL, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-019 A beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-020 On an accepted beat, in_data SHALL be written to buffer bits [cnt*W : cnt*W+W-1] and cnt SHALL increment.
REQ-021 An accepted beat with cnt = N/W-1 SHALL move the block to HOLD, with out_valid = 1 on the next cycle and cnt wrapped to 0.
REQ-022 The same condition, zero-cycle-later, restated: the first out_valid SHALL occur one cycle after the final accepted beat.
REQ-023 out_data SHALL equal the buffer at all times and SHALL remain stable throughout HOLD.
REQ-024 In HOLD, an edge with out_ready = 1 SHALL return the block to FILL, increment frames (wrapping 255 to 0), and make in_ready = 1 on the next cycle.
REQ-025 HOLD SHALL always take at least one cycle; no beat is accepted in the cycle where out_ready is taken.
REQ-026 An accepted beat with in_last = 1 and cnt < N/W-1 (early last) SHALL pulse err, discard the partial frame (cnt set to 0), and keep the block in FILL.
REQ-027 On an early last, buffer contents SHALL be left as written, and the next frame SHALL overwrite them.
REQ-028 A final beat (cnt = N/W-1) with in_last = 0 SHALL still complete the frame and enter HOLD, and SHALL pulse err.
REQ-029 err SHALL be 1 for exactly the cycle after the offending beat, and 0 otherwise.
REQ-030 in_valid = 0 in FILL SHALL leave cnt and the buffer unchanged; gaps between beats are allowed.
REQ-031 out_ready while in FILL SHALL be ignored.

Reset
REQ-032 While rst_n = 0, independent of clk, the block SHALL set: state FILL, cnt 0, buffer all zeros, out_valid 0, err 0, frames 0.
REQ-033 During reset, in_ready SHALL be 0; in_ready SHALL go to 1 on the first cycle after rst_n is deasserted.
REQ-034 A reset asserted mid-frame or in HOLD SHALL drop the frame without an err pulse or frames increment.

Verification
REQ-035 Scenario: 16 back-to-back beats 0x00..0x0F, in_last on beat 15 -> out_valid 1 cycle later; out_data = 0x000102...0E0F; in_ready 0; err never 1.
REQ-036 Scenario: same frame with out_ready held 0 for 5 cycles, then 1 -> out_data stable for all 5 cycles; frames 0 to 1; in_ready 1 on the next cycle.
REQ-037 Scenario: in_last on beat 4 -> err pulse 1 cycle; no out_valid; the next 16-beat frame of 0xFF gives out_data all ones.
REQ-038 Scenario: 16 beats with in_last never asserted -> HOLD is entered and err pulses once, after beat 15.
REQ-039 Scenario: rst_n pulled low after beat 9 -> out_valid 0, out_data 0, cnt 0 immediately (asynchronously); after release, a full frame loads correctly.
REQ-040 Scenario: 256 consecutive frames with out_ready tied 1 -> frames wraps to 0; each HOLD lasts exactly 1 cycle.
